alu_issue_ctrl: RTL and testbench

Initiator side of the 32-bit ALU interface: accepts one MIPS instruction plus its register operands over a valid/ready handshake, decodes it to a 3-bit ALU op and operand pair, drives the ALU, captures its result and zero flag, and presents a registered writeback/branch record downstream. It sits between register read and writeback in the multi-cycle datapath. The ALU itself stays external and combinational.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_decode.sv | 84 ++++++++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, MIPS opcode/funct
// values, FSM state encoding and the decoded-instruction record.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SIGN = 2'd1,
        IMM_ZERO = 2'd2
    } imm_sel_t;

    typedef struct packed {
        logic [2:0] op;
        imm_sel_t   imm_sel;
        logic [4:0] dest;
        logic       wen;
        logic       is_beq;
        logic       is_bne;
        logic       err;
    } dec_t;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
        return sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: instruction word to ALU op, immediate selection,
// writeback destination/enable, branch kind and unsupported-instruction flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[31:26];
    assign w_funct       = i_instr[5:0];
    assign w_rt          = i_instr[20:16];
    assign w_rd          = i_instr[15:11];
    assign w_unused_bits = ^{i_instr[25:21], i_instr[10:6]};

    // NOTE: every field gets a default first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        o_dec         = '0;
        o_dec.op      = ALU_AND;
        o_dec.imm_sel = IMM_NONE;
        case (w_opcode)
            OP_RTYPE: begin
                o_dec.dest = w_rd;
                o_dec.wen  = 1'b1;
                case (w_funct)
                    FN_ADD:  o_dec.op = ALU_ADD;
                    FN_SUB:  o_dec.op = ALU_SUB;
                    FN_AND:  o_dec.op = ALU_AND;
                    FN_OR:   o_dec.op = ALU_OR;
                    FN_SLT:  o_dec.op = ALU_SLT;
                    default: begin
                        o_dec.dest = 5'd0;
                        o_dec.wen  = 1'b0;
                        o_dec.err  = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_LW: begin
                o_dec.op      = ALU_ADD;
                o_dec.imm_sel = IMM_SIGN;
                o_dec.dest    = w_rt;
                o_dec.wen     = 1'b1;
            end
            OP_SLTI: begin
                o_dec.op      = ALU_SLT;
                o_dec.imm_sel = IMM_SIGN;
                o_dec.dest    = w_rt;
                o_dec.wen     = 1'b1;
            end
            OP_ANDI: begin
                o_dec.op      = ALU_AND;
                o_dec.imm_sel = IMM_ZERO;
                o_dec.dest    = w_rt;
                o_dec.wen     = 1'b1;
            end
            OP_ORI: begin
                o_dec.op      = ALU_OR;
                o_dec.imm_sel = IMM_ZERO;
                o_dec.dest    = w_rt;
                o_dec.wen     = 1'b1;
            end
            OP_SW: begin
                o_dec.op      = ALU_ADD;
                o_dec.imm_sel = IMM_SIGN;
            end
            OP_BEQ: begin
                o_dec.op     = ALU_SUB;
                o_dec.is_beq = 1'b1;
            end
            OP_BNE: begin
                o_dec.op     = ALU_SUB;
                o_dec.is_bne = 1'b1;
            end
            default: o_dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: accepts an instruction plus operands, drives the external ALU for one
// cycle, then holds a registered writeback/branch record until downstream takes it.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_taken,
    output logic        out_err
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_capture;
    dec_t        w_dec;
    logic [31:0] w_alu_a_next;
    logic [31:0] w_alu_b_next;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic [31:0] r_result;
    logic [4:0]  r_dest;
    logic        r_wen;
    logic        r_is_beq;
    logic        r_is_bne;
    logic        r_taken;
    logic        r_err;

    alu_decode u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // In DONE a new instruction is taken on the same edge the record is consumed.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture    = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_accept     = in_valid;
                    w_state_next = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_alu_a_next = w_dec.err ? 32'd0 : in_rs_val;
        case (w_dec.imm_sel)
            IMM_SIGN: w_alu_b_next = extend_imm(in_instr[15:0], 1'b1);
            IMM_ZERO: w_alu_b_next = extend_imm(in_instr[15:0], 1'b0);
            default:  w_alu_b_next = in_rt_val;
        endcase
        if (w_dec.err) w_alu_b_next = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= ALU_AND;
            r_result <= '0;
            r_dest   <= '0;
            r_wen    <= 1'b0;
            r_is_beq <= 1'b0;
            r_is_bne <= 1'b0;
            r_taken  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_alu_a_next;
                r_alu_b  <= w_alu_b_next;
                r_alu_op <= w_dec.op;
                r_dest   <= w_dec.dest;
                r_wen    <= w_dec.wen;
                r_is_beq <= w_dec.is_beq;
                r_is_bne <= w_dec.is_bne;
                r_err    <= w_dec.err;
            end
            if (w_capture) begin
                r_result <= alu_z;
                r_taken  <= (r_is_beq & alu_zero) | (r_is_bne & ~alu_zero);
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign out_result = r_result;
    assign out_dest   = r_dest;
    assign out_wen    = r_wen;
    assign out_taken  = r_taken;
    assign out_err    = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: provides the combinational ALU, predicts each record from
// the instruction semantics and checks every valid output cycle, plus directed literals.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_taken;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs_val  (in_rs_val),
        .in_rt_val  (in_rt_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_z      (alu_z),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .out_wen    (out_wen),
        .out_taken  (out_taken),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External combinational ALU.
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_z = 32'd0;
        endcase
        alu_zero = (alu_z == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_BAD} kind_t;
    typedef enum {B_RT, B_SEXT, B_ZEXT} bsrc_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        wen;
        logic        taken;
        logic        err;
        int          acc;
        bit          seen;
    } exp_t;

    function automatic exp_t predict(input logic [31:0] instr, input logic [31:0] rs,
                                     input logic [31:0] rt);
        exp_t  e;
        kind_t k;
        bsrc_t bs;
        logic  writes;
        logic  to_rd;
        logic  is_beq;
        logic  is_bne;
        logic [15:0] imm;
        imm    = instr[15:0];
        k      = K_BAD;
        bs     = B_RT;
        writes = 1'b1;
        to_rd  = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        case (instr[31:26])
            6'h00: begin
                to_rd = 1'b1;
                case (instr[5:0])
                    6'h20: k = K_ADD;
                    6'h22: k = K_SUB;
                    6'h24: k = K_AND;
                    6'h25: k = K_OR;
                    6'h2A: k = K_SLT;
                    default: k = K_BAD;
                endcase
            end
            6'h08: begin k = K_ADD; bs = B_SEXT; end
            6'h0A: begin k = K_SLT; bs = B_SEXT; end
            6'h0C: begin k = K_AND; bs = B_ZEXT; end
            6'h0D: begin k = K_OR;  bs = B_ZEXT; end
            6'h23: begin k = K_ADD; bs = B_SEXT; end
            6'h2B: begin k = K_ADD; bs = B_SEXT; writes = 1'b0; end
            6'h04: begin k = K_SUB; writes = 1'b0; is_beq = 1'b1; end
            6'h05: begin k = K_SUB; writes = 1'b0; is_bne = 1'b1; end
            default: k = K_BAD;
        endcase
        e = '{a: 32'd0, b: 32'd0, op: 3'd0, res: 32'd0, dest: 5'd0, wen: 1'b0,
              taken: 1'b0, err: 1'b0, acc: 0, seen: 1'b0};
        if (k == K_BAD) begin
            e.err = 1'b1;
            return e;
        end
        e.a = rs;
        case (bs)
            B_SEXT:  e.b = {{16{imm[15]}}, imm};
            B_ZEXT:  e.b = {16'h0000, imm};
            default: e.b = rt;
        endcase
        case (k)
            K_ADD: begin e.op = 3'b010; e.res = e.a + e.b; end
            K_SUB: begin e.op = 3'b110; e.res = e.a - e.b; end
            K_AND: begin e.op = 3'b000; e.res = e.a & e.b; end
            K_OR:  begin e.op = 3'b001; e.res = e.a | e.b; end
            default: begin
                e.op  = 3'b111;
                e.res = ($signed(e.a) < $signed(e.b)) ? 32'd1 : 32'd0;
            end
        endcase
        e.wen   = writes;
        e.dest  = writes ? (to_rd ? instr[15:11] : instr[20:16]) : 5'd0;
        e.taken = (is_beq && rs == rt) || (is_bne && rs != rt);
        return e;
    endfunction

    exp_t q[$];

    // Compare every valid output cycle against the oldest outstanding prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!e.seen) begin
                        check("latency", 32'(cyc - e.acc), 32'd2);
                        q[0].seen = 1'b1;
                    end
                    check("m_result", out_result, e.res);
                    check("m_dest",   32'(out_dest), 32'(e.dest));
                    check("m_wen",    32'(out_wen), 32'(e.wen));
                    check("m_taken",  32'(out_taken), 32'(e.taken));
                    check("m_err",    32'(out_err), 32'(e.err));
                    check("m_alu_a",  alu_a, e.a);
                    check("m_alu_b",  alu_b, e.b);
                    check("m_alu_op", 32'(alu_op), 32'(e.op));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e     = predict(in_instr, in_rs_val, in_rt_val);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Call positioned just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, output int acc);
        in_instr  = instr;
        in_rs_val = rs;
        in_rt_val = rt;
        in_valid  = 1'b1;
        acc       = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        int acc;
        @(posedge clk);
        #1;
        send(instr, rs, rt, acc);
        in_valid = 1'b0;
        wait_out();
    endtask

    initial begin
        int acc1;
        int acc2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_dest",   32'(out_dest), 32'd0);
        check("rst_out_wen",    32'(out_wen), 32'd0);
        check("rst_out_taken",  32'(out_taken), 32'd0);
        check("rst_out_err",    32'(out_err), 32'd0);
        check("rst_alu_a",      alu_a, 32'd0);
        check("rst_alu_b",      alu_b, 32'd0);
        check("rst_alu_op",     32'(alu_op), 32'd0);
        rst_n = 1'b1;

        // add $3,$1,$2
        run_op(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        check("add_op",     32'(alu_op), 32'h2);
        check("add_result", out_result, 32'd12);
        check("add_dest",   32'(out_dest), 32'd3);
        check("add_wen",    32'(out_wen), 32'd1);

        // slti $4,$1,-1 with rs = -2
        run_op(itype(6'h0A, 5'd1, 5'd4, 16'hFFFF), 32'hFFFF_FFFE, 32'd0);
        check("slti_alu_b",  alu_b, 32'hFFFF_FFFF);
        check("slti_op",     32'(alu_op), 32'h7);
        check("slti_result", out_result, 32'd1);
        check("slti_dest",   32'(out_dest), 32'd4);

        // ori $5,$0,0x8000
        run_op(itype(6'h0D, 5'd0, 5'd5, 16'h8000), 32'd0, 32'd0);
        check("ori_alu_b",  alu_b, 32'h0000_8000);
        check("ori_result", out_result, 32'h0000_8000);

        // Branches
        run_op(itype(6'h04, 5'd1, 5'd2, 16'h0003), 32'd9, 32'd9);
        check("beq_taken", 32'(out_taken), 32'd1);
        check("beq_wen",   32'(out_wen), 32'd0);
        check("beq_dest",  32'(out_dest), 32'd0);
        run_op(itype(6'h05, 5'd1, 5'd2, 16'h0003), 32'd9, 32'd9);
        check("bne_eq_taken", 32'(out_taken), 32'd0);
        run_op(itype(6'h05, 5'd1, 5'd2, 16'h0003), 32'd9, 32'd8);
        check("bne_ne_taken", 32'(out_taken), 32'd1);

        // Assorted encodings checked by the model
        run_op(itype(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h0000_0100, 32'd77);
        check("sw_result", out_result, 32'h0000_00FC);
        check("sw_wen",    32'(out_wen), 32'd0);
        run_op(itype(6'h0C, 5'd1, 5'd9, 16'h8001), 32'hFFFF_FFFF, 32'd0);
        check("andi_result", out_result, 32'h0000_8001);
        run_op(rtype(5'd1, 5'd2, 5'd0, 6'h2A), 32'hFFFF_FFFB, 32'd3);
        check("slt_result", out_result, 32'd1);
        check("slt_dest0_wen", 32'(out_wen), 32'd1);
        run_op(rtype(5'd1, 5'd2, 5'd7, 6'h00), 32'd3, 32'd4);
        check("badfn_err", 32'(out_err), 32'd1);

        // Backpressure: hold the sub record for 5 cycles with the next instruction waiting
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(rtype(5'd4, 5'd5, 5'd6, 6'h22), 32'd20, 32'd3, acc1);
        in_valid = 1'b0;
        wait_out();
        check("bp_sub_result", out_result, 32'd17);
        @(posedge clk);
        #1;
        in_instr  = rtype(5'd7, 5'd8, 5'd9, 6'h24);
        in_rs_val = 32'h0000_F0F0;
        in_rt_val = 32'h0000_FF00;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold",      out_result, 32'd17);
            check("bp_hold_dest", 32'(out_dest), 32'd6);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        acc2 = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out();
        check("bp_second_latency", 32'(cyc - acc2), 32'd2);
        check("bp_and_result", out_result, 32'h0000_F000);

        // Unknown opcode
        run_op({6'h3F, 26'h0123456}, 32'hDEAD_BEEF, 32'h1234_5678);
        check("bad_err",   32'(out_err), 32'd1);
        check("bad_wen",   32'(out_wen), 32'd0);
        check("bad_alu_a", alu_a, 32'd0);
        check("bad_alu_b", alu_b, 32'd0);

        // Back-to-back with in_valid held high
        @(posedge clk);
        #1;
        send(itype(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd100, 32'd0, acc1);
        send(itype(6'h23, 5'd3, 5'd4, 16'h0010), 32'h0000_1000, 32'd0, acc2);
        in_valid = 1'b0;
        check("throughput", 32'(acc2 - acc1), 32'd2);
        wait_out();
        check("lw_result", out_result, 32'h0000_1010);
        check("lw_dest",   32'(out_dest), 32'd4);

        // Reset while in EXEC discards the instruction
        @(posedge clk);
        #1;
        send(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd1, 32'd1, acc1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_exec_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(rtype(5'd1, 5'd2, 5'd10, 6'h25), 32'h0000_00F0, 32'h0000_000F);
        check("post_rst_result", out_result, 32'h0000_00FF);
        check("post_rst_dest",   32'(out_dest), 32'd10);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
